reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Sequential read-side master for the 32×32 register file: on a start pulse it walks a programmable, optionally wrapping range of register indices through a spare register-file read port. Each register value is captured and streamed out over a valid/ready handshake, together with its index. It sits between the register file and the debug/trace path, so architectural state can be dumped without stalling the datapath.

## Interface
Parameters:
- DW, 32, data width of a register word.
- AW, 5, register index width; the register count is 2**AW.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  cancels a dump in progress.
- first_reg  in  AW  first index to read; latched on accepted start.
- last_reg  in  AW  last index to read; latched on accepted start.
- ReadReg  out  AW  index driven to the register-file read port.
- ReadData  in  DW  combinational read data from the register file for ReadReg.
- dout  out  DW  captured register value.
- didx  out  AW  index of the value in dout.
- dvalid  out  1  dout/didx valid.
- dready  in  1  downstream accepts the word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final word is accepted.

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE:
  - start=1 latches first_reg/last_reg, sets the current index cur to first_reg, drives ReadReg=first_reg and goes to READ.
  - start=0 leaves the block in IDLE.
- READ: captures dout<=ReadData and didx<=cur, sets dvalid<=1, goes to HOLD.
- HOLD:
  - dout, didx and dvalid are held stable while dready=0.
  - On dvalid&dready with cur==last: dvalid<=0, go to DONE.
  - On dvalid&dready otherwise: cur<=cur+1 modulo 2**AW (31 wraps to 0), ReadReg follows, dvalid<=0, go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Word count is ((last_reg − first_reg) mod 2**AW)+1.
  - first==last gives 1 word.
  - first=0, last=31 gives 32 words.
  - first=30, last=1 gives indices 30,31,0,1.
- start while busy=1 is ignored; the latched range does not change.
- abort=1 in READ, HOLD or DONE: next edge returns to IDLE with dvalid=0, and done is not pulsed. A word being handshaked in the same cycle counts as transferred. abort in IDLE has no effect, and abort has priority over start in the same cycle.
- Register-file writes during a dump are not blocked. Each word reflects the register contents in its READ cycle.
- ReadReg is registered; it changes only on a clock edge.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, ReadReg=0, dout=0, didx=0, dvalid=0, busy=0, done=0, cur=0, latched range=0.
- Reset applied mid-dump takes effect immediately with no done pulse. Operation resumes from IDLE on the first edge after rst rises.
- Start sampled at edge 0 → READ during cycle 1 → dvalid=1 after edge 2.
- A handshake at edge n → dvalid=0 during cycle n+1 → next word valid after edge n+2. Peak throughput is one word per 2 cycles.
- Last handshake at edge n → done=1 during cycle n+1 → IDLE after edge n+2, when busy=0.
- A full 32-word dump with dready tied high takes 64 cycles from start to done plus one cycle of DONE.
- dvalid never drops without a handshake, except on abort or reset.

## Configuration
- REGDUMP_PARITY_EN defined:
  - Adds output dpar (1 bit), the even parity of dout (^dout), registered with dout.
  - dpar resets to 0 and is held stable with dout in HOLD.
- REGDUMP_PARITY_EN undefined: the dpar port and its logic are absent; all other behaviour is identical.

## Test plan
- Full dump:
  - Stimulus: register file preloaded with rN=N*0x01010101, first=0, last=31, dready=1.
  - Required: 32 words with didx 0..31 and matching dout; done pulses once; busy is high from the cycle after start through DONE.
- Wrap range:
  - Stimulus: first=30, last=1.
  - Required: didx sequence 30,31,0,1, then done; exactly 4 handshakes.
- Backpressure:
  - Stimulus: first=last=5, r5=0xDEADBEEF, dready low for 7 cycles after dvalid.
  - Required: dout=0xDEADBEEF and didx=5 stable for all 7 cycles; one transfer when dready rises; done follows.
- Abort and ignored start:
  - Stimulus: start a 0..31 dump, pulse start again on the third word, abort on the fifth word with dready=0.
  - Required: the second start has no effect; after abort, dvalid=0, no done pulse, busy=0.
- Async reset mid-dump:
  - Stimulus: drop rst between edges while in HOLD.
  - Required: dvalid, busy, dout and ReadReg go to 0 immediately without a clock edge; a new start after rst rises dumps normally.
- Parity (REGDUMP_PARITY_EN defined):
  - Stimulus: r3=0x00000007, then r4=0x00000003.
  - Required: dpar=1 for r3 and dpar=0 for r4.

Source files
------------

// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
//
// Read-side master that walks a programmable, optionally wrapping range of
// register-file indices through a spare read port. It captures each value
// and streams it downstream over a valid/ready handshake, together with the
// index it came from. Architectural state can then be dumped to the debug or
// trace path without stalling the datapath.
//
// Optional feature macro: REGDUMP_PARITY_EN
//   When defined, adds output dpar, the even parity (^dout) of the captured
//   word. It is registered alongside dout.
//
// Ports
//   Clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   dump request, only honoured in IDLE
//   abort      in   cancel a dump in progress
//   first_reg  in   first index of the range, latched on accepted start
//   last_reg   in   last index of the range, latched on accepted start
//   ReadReg    out  registered index driven to the register-file read port
//   ReadData   in   combinational register-file data for ReadReg
//   dout       out  captured register value
//   didx       out  index of the value in dout
//   dvalid     out  dout/didx valid
//   dready     in   downstream accepts the word
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the final word is accepted
//   dpar       out  parity of dout (REGDUMP_PARITY_EN only)
// ---------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] first_reg,
    input  logic [AW-1:0] last_reg,
    output logic [AW-1:0] ReadReg,
    input  logic [DW-1:0] ReadData,
    output logic [DW-1:0] dout,
    output logic [AW-1:0] didx,
    output logic          dvalid,
    input  logic          dready,
    output logic          busy,
    output logic          done
`ifdef REGDUMP_PARITY_EN
    ,
    output logic          dpar
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] last_q, last_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [AW-1:0] didx_q, didx_d;
    logic          dvalid_q, dvalid_d;
`ifdef REGDUMP_PARITY_EN
    logic          dpar_q, dpar_d;
`endif

    logic start_ok;
    logic handshake;
    logic at_last;

    // Abort wins over start; start is otherwise honoured only in IDLE.
    assign start_ok  = start && !abort;
    assign handshake = dvalid_q && dready;
    assign at_last   = (cur_q == last_q);

    // State register.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = abort ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (handshake) begin
                    state_d = at_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are pure decodes of the state so that an async reset
    // clears them immediately.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath next values. cur doubles as the read-port index, so ReadReg
    // is registered and only moves on a clock edge. The increment simply
    // overflows the AW-bit counter, giving the 31 -> 0 wrap.
    always_comb begin
        cur_d    = cur_q;
        last_d   = last_q;
        dout_d   = dout_q;
        didx_d   = didx_q;
        dvalid_d = dvalid_q;
`ifdef REGDUMP_PARITY_EN
        dpar_d   = dpar_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    cur_d  = first_reg;
                    last_d = last_reg;
                end
            end
            S_READ: begin
                if (!abort) begin
                    dout_d   = ReadData;
                    didx_d   = cur_q;
                    dvalid_d = 1'b1;
`ifdef REGDUMP_PARITY_EN
                    dpar_d   = ^ReadData;
`endif
                end
            end
            S_HOLD: begin
                if (abort) begin
                    dvalid_d = 1'b0;
                end else if (handshake) begin
                    dvalid_d = 1'b0;
                    if (!at_last) begin
                        cur_d = cur_q + AW'(1);
                    end
                end
            end
            default: begin
                dvalid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            cur_q    <= '0;
            last_q   <= '0;
            dout_q   <= '0;
            didx_q   <= '0;
            dvalid_q <= 1'b0;
`ifdef REGDUMP_PARITY_EN
            dpar_q   <= 1'b0;
`endif
        end else begin
            cur_q    <= cur_d;
            last_q   <= last_d;
            dout_q   <= dout_d;
            didx_q   <= didx_d;
            dvalid_q <= dvalid_d;
`ifdef REGDUMP_PARITY_EN
            dpar_q   <= dpar_d;
`endif
        end
    end

    assign ReadReg = cur_q;
    assign dout    = dout_q;
    assign didx    = didx_q;
    assign dvalid  = dvalid_q;
`ifdef REGDUMP_PARITY_EN
    assign dpar    = dpar_q;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
//
// Drives reg_dump_reader from a behavioural register file. A reference
// model predicts which indices must be streamed for each accepted start.
// It also tracks the expected busy/done/dvalid behaviour, and a single
// compare process checks the outputs on every falling edge. Directed
// scenarios add literal expectations on top of the model. Randomised dumps
// use $urandom for the contents, the ranges and dready.
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic          Clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dready = 1'b0;
    logic [AW-1:0] first_reg = '0;
    logic [AW-1:0] last_reg = '0;
    logic [AW-1:0] ReadReg;
    logic [AW-1:0] didx;
    logic [DW-1:0] ReadData;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic          busy;
    logic          done;
`ifdef REGDUMP_PARITY_EN
    logic          dpar;
`endif

    logic [DW-1:0] mem [NREG];

    int n_cmp    = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int idx_log[$];
    int par_log[$];

    // Reference model state: indices still owed, and expected status.
    int   exp_q[$];
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    logic m_dv   = 1'b0;
    logic m_pend = 1'b0;
    logic n_busy, n_done, n_dv, n_pend;

    assign ReadData = mem[ReadReg];

    always #5 Clk = ~Clk;

    reg_dump_reader #(.DW(DW), .AW(AW)) dut (
        .Clk       (Clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .ReadReg   (ReadReg),
        .ReadData  (ReadData),
        .dout      (dout),
        .didx      (didx),
        .dvalid    (dvalid),
        .dready    (dready),
        .busy      (busy),
        .done      (done)
`ifdef REGDUMP_PARITY_EN
        ,
        .dpar      (dpar)
`endif
    );

    task automatic check_output(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: wait expired at %0t", name, $time);
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Handshake bookkeeping in the model: the front index leaves the queue.
    task automatic model_accept();
        idx_log.push_back(exp_q[0]);
`ifdef REGDUMP_PARITY_EN
        par_log.push_back(int'(dpar));
`endif
        hs_cnt++;
        void'(exp_q.pop_front());
    endtask

    // Compare process: check the current cycle, then predict the next one.
    always @(negedge Clk) begin
        if (!rst) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dv   = 1'b0;
            m_pend = 1'b0;
        end else begin
            check_output("busy", busy, m_busy);
            check_output("done", done, m_done);
            check_output("dvalid", dvalid, m_dv);
            if (done) done_cnt++;
            if (m_pend && exp_q.size() > 0)
                check_output("ReadReg", ReadReg, exp_q[0]);
            if (m_dv && dvalid && exp_q.size() > 0) begin
                check_output("didx", didx, exp_q[0]);
                check_output("dout", dout, mem[exp_q[0]]);
`ifdef REGDUMP_PARITY_EN
                check_output("dpar", dpar, ^mem[exp_q[0]]);
`endif
            end

            n_busy = m_busy;
            n_done = 1'b0;
            n_dv   = m_dv;
            n_pend = 1'b0;
            if (!m_busy) begin
                if (start && !abort) begin
                    int cnt;
                    cnt = ((int'(last_reg) - int'(first_reg)) % NREG + NREG) % NREG + 1;
                    exp_q.delete();
                    for (int k = 0; k < cnt; k++)
                        exp_q.push_back((int'(first_reg) + k) % NREG);
                    n_busy = 1'b1;
                    n_pend = 1'b1;
                    n_dv   = 1'b0;
                end
            end else if (abort) begin
                if (m_dv && dready && exp_q.size() > 0) model_accept();
                exp_q.delete();
                n_busy = 1'b0;
                n_dv   = 1'b0;
            end else if (m_done) begin
                n_busy = 1'b0;
            end else if (m_pend) begin
                n_dv = 1'b1;
            end else if (m_dv && dready && exp_q.size() > 0) begin
                model_accept();
                n_dv = 1'b0;
                if (exp_q.size() == 0) n_done = 1'b1;
                else n_pend = 1'b1;
            end
            m_busy = n_busy;
            m_done = n_done;
            m_dv   = n_dv;
            m_pend = n_pend;
        end
    end

    // Issue one start and run until done or the cycle budget expires.
    // mode 0 keeps dready high; mode 1 randomises dready each cycle.
    task automatic apply_stimulus(input int f, input int l, input int mode, output int cyc);
        tick();
        first_reg = AW'(f);
        last_reg  = AW'(l);
        start     = 1'b1;
        dready    = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 600) begin
            if (mode == 1) dready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        if (!done) report_timeout("dump_done_wait");
    endtask

    initial begin
        int cyc, hs0, dn0, cnt, f, l;
        bit second_sent;

        for (int i = 0; i < NREG; i++) mem[i] = $urandom;
        repeat (3) tick();
        check_output("reset_dout", dout, 32'h0);
        check_output("reset_didx", didx, 0);
        check_output("reset_dvalid", dvalid, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_ReadReg", ReadReg, 0);
        rst = 1'b1;
        tick();

        $display("[TB] full dump 0..31");
        for (int i = 0; i < NREG; i++) mem[i] = i * 32'h01010101;
        idx_log.delete();
        hs0 = hs_cnt; dn0 = done_cnt;
        apply_stimulus(0, 31, 0, cyc);
        check_output("full_cycles", cyc, 64);
        tick();
        check_output("full_hs", hs_cnt - hs0, 32);
        check_output("full_done", done_cnt - dn0, 1);
        check_output("full_log_size", idx_log.size(), 32);
        for (int i = 0; i < idx_log.size() && i < NREG; i++)
            check_output("full_idx", idx_log[i], i);

        $display("[TB] wrap range 30..1");
        idx_log.delete();
        hs0 = hs_cnt;
        apply_stimulus(30, 1, 0, cyc);
        tick();
        check_output("wrap_hs", hs_cnt - hs0, 4);
        if (idx_log.size() == 4) begin
            check_output("wrap_idx0", idx_log[0], 30);
            check_output("wrap_idx1", idx_log[1], 31);
            check_output("wrap_idx2", idx_log[2], 0);
            check_output("wrap_idx3", idx_log[3], 1);
        end else begin
            check_output("wrap_log_size", idx_log.size(), 4);
        end

        $display("[TB] backpressure on r5");
        mem[5] = 32'hDEADBEEF;
        hs0 = hs_cnt; dn0 = done_cnt;
        tick();
        first_reg = 5; last_reg = 5; start = 1'b1; dready = 1'b0;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!dvalid && cnt < 20) begin tick(); cnt++; end
        if (!dvalid) report_timeout("bp_dvalid_wait");
        for (int i = 0; i < 7; i++) begin
            check_output("bp_dout", dout, 32'hDEADBEEF);
            check_output("bp_didx", didx, 5);
            check_output("bp_dvalid", dvalid, 1);
            tick();
        end
        dready = 1'b1;
        cnt = 0;
        while (!done && cnt < 20) begin tick(); cnt++; end
        if (!done) report_timeout("bp_done_wait");
        tick();
        check_output("bp_hs", hs_cnt - hs0, 1);
        check_output("bp_done", done_cnt - dn0, 1);

        $display("[TB] ignored start and abort");
        idx_log.delete();
        hs0 = hs_cnt; dn0 = done_cnt;
        tick();
        first_reg = 0; last_reg = 31; start = 1'b1; dready = 1'b1;
        tick();
        start = 1'b0;
        second_sent = 0;
        cnt = 0;
        while (cnt < 200) begin
            if (hs_cnt - hs0 == 2 && !second_sent) begin
                first_reg = 7; last_reg = 9; start = 1'b1; second_sent = 1;
            end else begin
                start = 1'b0;
            end
            if (hs_cnt - hs0 == 4) dready = 1'b0;
            if (!dready && dvalid) break;
            tick();
            cnt++;
        end
        start = 1'b0;
        if (cnt >= 200) report_timeout("abort_wait");
        check_output("abort_word_idx", didx, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("abort_dvalid", dvalid, 0);
        check_output("abort_busy", busy, 0);
        repeat (3) tick();
        check_output("abort_hs", hs_cnt - hs0, 4);
        check_output("abort_no_done", done_cnt - dn0, 0);
        if (idx_log.size() >= 3) check_output("abort_idx2", idx_log[2], 2);

        $display("[TB] async reset mid-dump");
        first_reg = 0; last_reg = 31; start = 1'b1; dready = 1'b0;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!dvalid && cnt < 20) begin tick(); cnt++; end
        if (!dvalid) report_timeout("rst_dvalid_wait");
        tick();
        #2 rst = 1'b0;
        #1;
        check_output("rst_dvalid", dvalid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_dout", dout, 32'h0);
        check_output("rst_ReadReg", ReadReg, 0);
        check_output("rst_done", done, 0);
        tick();
        rst = 1'b1;
        hs0 = hs_cnt; dn0 = done_cnt;
        apply_stimulus(12, 15, 1, cyc);
        tick();
        check_output("post_rst_hs", hs_cnt - hs0, 4);
        check_output("post_rst_done", done_cnt - dn0, 1);

`ifdef REGDUMP_PARITY_EN
        $display("[TB] parity r3/r4");
        mem[3] = 32'h00000007;
        mem[4] = 32'h00000003;
        par_log.delete();
        apply_stimulus(3, 4, 0, cyc);
        tick();
        if (par_log.size() == 2) begin
            check_output("par_r3", par_log[0], 1);
            check_output("par_r4", par_log[1], 0);
        end else begin
            check_output("par_log_size", par_log.size(), 2);
        end
`endif

        $display("[TB] randomised dumps");
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < NREG; i++) mem[i] = $urandom;
            f = $urandom_range(0, NREG - 1);
            l = $urandom_range(0, NREG - 1);
            hs0 = hs_cnt; dn0 = done_cnt;
            apply_stimulus(f, l, 1, cyc);
            tick();
            check_output("rand_hs", hs_cnt - hs0, ((l - f) % NREG + NREG) % NREG + 1);
            check_output("rand_done", done_cnt - dn0, 1);
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
